rv32i_mem_arbiter: RTL

RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

---
 rtl/rv32i_mem_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Two-master (instruction fetch / data) arbiter in front of a single-port
// memory with a one-shot strobe and an ack/timeout completion handshake.
// Only one transaction is outstanding at a time: IDLE -> ISSUE -> WAIT.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the grant between
// fetch and data on simultaneous requests. Without it the data side always
// wins a conflict.
module rv32i_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic        if_err,
  output logic [31:0] if_rdata,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic        dm_err,
  output logic [31:0] dm_rdata,
  // memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_DM  = 1'b1;
  // The counter is compared one step early so the abort fires in the
  // TIMEOUT-th WAIT cycle that sees no ack.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        owner_r;
  logic [7:0]  cnt_r;
  logic        grant_dm_s;
  logic        grant_s;
  logic        ack_s;
  logic        timeout_s;
  logic        done_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_owner_r;
`endif

  // Arbitration: pick the data side or the fetch side as the winner.
  always_comb begin
    grant_dm_s = 1'b0;
    if (if_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_dm_s = (last_owner_r == OWN_IF);
`else
      grant_dm_s = 1'b1;
`endif
    end else if (dm_req) begin
      grant_dm_s = 1'b1;
    end else begin
      grant_dm_s = 1'b0;
    end
  end

  // Completion conditions: ack beats a timeout landing in the same cycle.
  always_comb begin
    grant_s   = (state_r == IDLE) && (if_req || dm_req);
    ack_s     = (state_r == WAIT) && mem_ack;
    timeout_s = (state_r == WAIT) && !mem_ack && (cnt_r == TO_LAST);
    done_s    = ack_s || timeout_s;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs: same-cycle grants, held low while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst && grant_s) begin
      if_gnt = !grant_dm_s;
      dm_gnt = grant_dm_s;
    end else begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  // Latch the winner into the memory strobe registers (live only in ISSUE)
  // and remember which side owns the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r   <= OWN_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'h0;
    end else if (grant_s) begin
      mem_en <= 1'b1;
      if (grant_dm_s) begin
        owner_r   <= OWN_DM;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else begin
        owner_r   <= OWN_IF;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'h0000_0000;
        mem_be    <= 4'hF;
      end
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= 4'h0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Track the side granted most recently for conflict alternation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_r <= OWN_IF;
    end else if (grant_s) begin
      last_owner_r <= grant_dm_s;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`endif

  // WAIT-state cycle counter: cleared on issue, advances while no ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (state_r == ISSUE) begin
      cnt_r <= 8'd0;
    end else if ((state_r == WAIT) && !mem_ack) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Fetch completion: one-cycle rvalid/err pulse and data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'h0000_0000;
    end else if (done_s && (owner_r == OWN_IF)) begin
      if_rvalid <= 1'b1;
      if_err    <= timeout_s;
      if_rdata  <= ack_s ? mem_rdata : 32'h0000_0000;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= if_rdata;
    end
  end

  // Data completion: stores also return mem_rdata on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_rvalid <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= 32'h0000_0000;
    end else if (done_s && (owner_r == OWN_DM)) begin
      dm_rvalid <= 1'b1;
      dm_err    <= timeout_s;
      dm_rdata  <= ack_s ? mem_rdata : 32'h0000_0000;
    end else begin
      dm_rvalid <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= dm_rdata;
    end
  end

endmodule
